voted_gate_array: RTL and testbench
===================================

# voted_gate_array

Parametrised successor to the registered single-gate circuit wrapper. It accepts operand pairs over a valid/ready handshake and selects one of four bitwise gate functions per transaction. Each transaction is evaluated REPLICAS times through a fault-injecting gate model, and the output is the per-bit majority vote, registered. It sits between the stimulus driver and the result scoreboard in the unreliable-gate simulation environment, and it reports how often the replicas disagree.

## Interface
- N, 10: operand/result width in bits, 1..64.
- REPLICAS, 3: evaluations per transaction; odd, 1..15.
- ERROR_PROBABILITY, 0: per-bit flip probability in units of 1/65536, 0..65535.
- SEED, 16'h1D2B: base seed for the fault LFSRs.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  block can accept an operand pair.
- x_i  in  N  operand A.
- y_i  in  N  operand B.
- op_i  in  2  gate function: 00 NAND, 01 NOR, 10 AND, 11 XOR.
- z_o  out  N  voted result.
- disagree_o  out  1  at least one bit of the result had non-unanimous replicas.
- out_valid_o  out  1  z_o and disagree_o are valid.
- out_ready_i  in  1  consumer accepts the result.
- err_count_o  out  16  count of results delivered with disagree set; saturates at 16'hFFFF.
- err_clr_i  in  1  synchronous clear of err_count_o.

## Operation
- FSM states:
  - IDLE: in_ready_o=1.
  - EVAL: replica index r counts 0..REPLICAS-1.
  - OUT: out_valid_o=1.
- IDLE→EVAL on in_valid_i&&in_ready_o. x_i, y_i and op_i are captured into internal registers; later input changes are ignored. The per-bit vote counters clear to 0 and r clears to 0.
- Each EVAL cycle:
  - ideal = op(x,y) on the captured operands.
  - replica = ideal XOR fmask.
  - fmask[i]=1 iff lfsr_i < ERROR_PROBABILITY.
  - vote counter of bit i += replica[i].
  - All LFSRs advance once; r increments.
- Fault LFSRs:
  - One 16-bit Fibonacci LFSR per bit, polynomial x^16+x^14+x^13+x^11+1.
  - Seed of lfsr_i = (SEED+i) mod 2^16, with 0 replaced by 16'hACE1.
  - LFSRs advance only in EVAL.
- On the last EVAL edge (r==REPLICAS-1), using counts that include that replica:
  - z_o[i] = (count_i > REPLICAS/2).
  - disagree_o = 1 if any count_i is neither 0 nor REPLICAS.
  - State goes to OUT.
- OUT→IDLE on out_valid_o&&out_ready_i. On that same edge err_count_o increments if disagree_o=1 and err_count_o<16'hFFFF.
- z_o and disagree_o hold their values after the handshake until the next result is registered.
- err_clr_i=1 forces err_count_o to 0 on that edge. It takes priority over a simultaneous increment.
- ERROR_PROBABILITY=0: no flips ever occur, z_o equals the ideal result, and disagree_o=0.
- Vote counter width is clog2(REPLICAS+1). Counters cannot overflow.

## Timing
- Reset values: in_ready_o=1, out_valid_o=0, z_o=0, disagree_o=0, err_count_o=0, state IDLE, LFSRs at their seeds.
- Reset mid-EVAL or mid-OUT aborts the transaction and no result is delivered. LFSRs return to their seeds.
- Accept edge at cycle T: in_ready_o is low from T+1.
- out_valid_o rises at T+REPLICAS, after REPLICAS EVAL edges.
- out_valid_o stays high and z_o stays stable while out_ready_i=0, for any length of backpressure.
- Output handshake at edge U: in_ready_o is high from U+1. There is no same-cycle bypass.
- Minimum period between accepts is REPLICAS+2 cycles, with out_ready_i held high.
- in_valid_i is ignored outside IDLE. The block has no input buffering.

## Test plan
- NAND, zero error: N=10, REPLICAS=3, EP=0. Drive x=10'h3FF, y=10'h3FF, op=00. Required: z_o=10'h000, disagree_o=0, out_valid_o exactly 3 cycles after the accept edge. Then x=10'h0F0, y=10'h0FF → z_o=10'h30F.
- All ops, zero error: x=10'h2AA, y=10'h155. Required: NOR→10'h000, AND→10'h000, XOR→10'h3FF. After each delivery, err_count_o remains 0.
- Backpressure: hold out_ready_i=0 for 20 cycles after out_valid_o rises. Required: z_o stable, in_ready_o=0 throughout, and in_valid_i pulses are ignored. Release → in_ready_o=1 on the next cycle.
- Reset mid-EVAL: assert reset on EVAL cycle 1. Required: out_valid_o=0 immediately (asynchronous) and in_ready_o=1. No result is delivered. A rerun of the same transaction matches the first-run golden value, because the LFSRs re-seed.
- Noisy voting: EP=16384, REPLICAS=5, SEED=16'h1D2B, 200 random transactions. Required: z_o, disagree_o and err_count_o match a bit-accurate LFSR/vote reference model on every output handshake.
- Counter saturation and clear: preload err_count_o to 16'hFFFE through a run at EP=32768. Required: it saturates at 16'hFFFF, holding there on further disagreements. err_clr_i coinciding with an increment → 0.

Source files
------------

// File: rtl/voted_gate_array.sv
// voted_gate_array: replicated bitwise gate with per-bit fault injection and majority vote.
// Each accepted operand pair is evaluated REPLICAS times; the result flags replica disagreement.
module voted_gate_array #(
    parameter int unsigned N                 = 10,
    parameter int unsigned REPLICAS          = 3,
    parameter int unsigned ERROR_PROBABILITY = 0,
    parameter logic [15:0] SEED              = 16'h1D2B
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    input  logic [1:0]   op_i,
    output logic [N-1:0] z_o,
    output logic         disagree_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [15:0]  err_count_o,
    input  logic         err_clr_i
);
    localparam int unsigned   CW     = $clog2(REPLICAS + 1);
    localparam logic [CW-1:0] HALF   = CW'(REPLICAS / 2);
    localparam logic [CW-1:0] ALL    = CW'(REPLICAS);
    localparam logic [CW-1:0] LAST   = CW'(REPLICAS - 1);
    localparam logic [16:0]   THRESH = 17'(ERROR_PROBABILITY);

    typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;

    state_t               state_q;
    logic [N-1:0]         x_q, y_q;
    logic [1:0]           op_q;
    logic [CW-1:0]        r_q;
    logic [N-1:0][CW-1:0] cnt_q, cnt_d;
    logic [N-1:0][15:0]   lfsr_q, lfsr_d;
    logic [N-1:0]         ideal, fmask, replica, vote, mixed;
    logic [16:0]          diff;
    logic                 in_ready_q, out_valid_q, disagree_q;
    logic [N-1:0]         z_q;
    logic [15:0]          err_q;

    function automatic logic [15:0] seed_of(int unsigned i);
        logic [15:0] s;
        s = SEED + 16'(i);
        return (s == 16'h0000) ? 16'hACE1 : s;
    endfunction

    // One replica evaluation: ideal gate, fault mask from the LFSR borrow, vote accumulation.
    always_comb begin
        ideal   = '0;
        fmask   = '0;
        replica = '0;
        vote    = '0;
        mixed   = '0;
        diff    = '0;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        case (op_q)
            2'b00:   ideal = ~(x_q & y_q);
            2'b01:   ideal = ~(x_q | y_q);
            2'b10:   ideal = x_q & y_q;
            default: ideal = x_q ^ y_q;
        endcase
        for (int unsigned i = 0; i < N; i++) begin
            diff       = {1'b0, lfsr_q[i]} - THRESH;
            fmask[i]   = diff[16];
            replica[i] = ideal[i] ^ fmask[i];
            cnt_d[i]   = cnt_q[i] + CW'(replica[i]);
            vote[i]    = cnt_d[i] > HALF;
            mixed[i]   = (cnt_d[i] != '0) && (cnt_d[i] != ALL);
            lfsr_d[i]  = {lfsr_q[i][0] ^ lfsr_q[i][2] ^ lfsr_q[i][3] ^ lfsr_q[i][5],
                          lfsr_q[i][15:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            disagree_q  <= 1'b0;
            err_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            op_q        <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                lfsr_q[i] <= seed_of(i);
            end
        end else begin
            // Clear wins over a coinciding increment.
            if (err_clr_i) begin
                err_q <= '0;
            end else if (out_valid_q && out_ready_i && disagree_q && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end
            case (state_q)
                IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        x_q        <= x_i;
                        y_q        <= y_i;
                        op_q       <= op_i;
                        cnt_q      <= '0;
                        r_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= EVAL;
                    end
                end
                EVAL: begin
                    lfsr_q <= lfsr_d;
                    cnt_q  <= cnt_d;
                    r_q    <= r_q + CW'(1);
                    if (r_q == LAST) begin
                        z_q         <= vote;
                        disagree_q  <= |mixed;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign z_o         = z_q;
    assign disagree_o  = disagree_q;
    assign err_count_o = err_q;

endmodule

// File: tb/tb_voted_gate_array.sv
// Bench for voted_gate_array: three instances (clean R=3, noisy R=5, heavy-noise R=3)
// checked against a bit-level LFSR/vote model through a scoreboard queue.
`timescale 1ns/1ps
module tb_voted_gate_array;
    localparam int unsigned W  = 10;
    localparam int          ND = 3;

    typedef struct packed {
        logic [W-1:0] z;
        logic         dis;
    } exp_t;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [1:0]   op;
        logic [W-1:0] z;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst       [ND];
    logic         in_valid  [ND];
    logic         in_ready  [ND];
    logic [W-1:0] x         [ND];
    logic [W-1:0] y         [ND];
    logic [1:0]   op        [ND];
    logic [W-1:0] z         [ND];
    logic         dis       [ND];
    logic         out_valid [ND];
    logic         out_ready [ND];
    logic [15:0]  err       [ND];
    logic         err_clr   [ND];

    voted_gate_array #(.N(W), .REPLICAS(3), .ERROR_PROBABILITY(0), .SEED(16'h1D2B)) dut_a (
        .clk(clk), .reset(rst[0]), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .x_i(x[0]), .y_i(y[0]), .op_i(op[0]), .z_o(z[0]), .disagree_o(dis[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .err_count_o(err[0]),
        .err_clr_i(err_clr[0]));

    voted_gate_array #(.N(W), .REPLICAS(5), .ERROR_PROBABILITY(16384), .SEED(16'h1D2B)) dut_b (
        .clk(clk), .reset(rst[1]), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .x_i(x[1]), .y_i(y[1]), .op_i(op[1]), .z_o(z[1]), .disagree_o(dis[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .err_count_o(err[1]),
        .err_clr_i(err_clr[1]));

    voted_gate_array #(.N(W), .REPLICAS(3), .ERROR_PROBABILITY(32768), .SEED(16'h1D2B)) dut_c (
        .clk(clk), .reset(rst[2]), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
        .x_i(x[2]), .y_i(y[2]), .op_i(op[2]), .z_o(z[2]), .disagree_o(dis[2]),
        .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]), .err_count_o(err[2]),
        .err_clr_i(err_clr[2]));

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb [$];
    logic [15:0] ml [ND][W];
    logic [15:0] exp_err [ND];
    vec_t        vecs [8];

    function automatic int reps(input int d);
        return (d == 1) ? 5 : 3;
    endfunction

    function automatic int ep(input int d);
        case (d)
            1:       return 16384;
            2:       return 32768;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic b;
        b = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {b, l[15:1]};
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    task automatic model_seed(input int d);
        logic [15:0] s;
        for (int i = 0; i < int'(W); i++) begin
            s = 16'h1D2B + 16'(i);
            ml[d][i] = (s == 16'h0000) ? 16'hACE1 : s;
        end
    endtask

    // Bit-serial reference: per bit, run every replica against that bit's own LFSR.
    task automatic model_eval(input int d, input logic [W-1:0] xa, input logic [W-1:0] ya,
                              input logic [1:0] opa, output logic [W-1:0] zo, output logic diso);
        logic [W-1:0] ideal;
        int ones;
        case (opa)
            2'b00:   ideal = ~(xa & ya);
            2'b01:   ideal = ~(xa | ya);
            2'b10:   ideal = xa & ya;
            default: ideal = xa ^ ya;
        endcase
        zo   = '0;
        diso = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            ones = 0;
            for (int r = 0; r < reps(d); r++) begin
                if ((int'(ml[d][i]) < ep(d)) != ideal[i]) ones++;
                ml[d][i] = lfsr_next(ml[d][i]);
            end
            zo[i] = (2 * ones > reps(d));
            if (ones != 0 && ones != reps(d)) diso = 1'b1;
        end
    endtask

    task automatic start(input int d, input logic [W-1:0] xa, input logic [W-1:0] ya, input logic [1:0] opa);
        exp_t e;
        @(negedge clk);
        check("in_ready_before_accept", d, 32'(in_ready[d]), 32'd1);
        x[d] = xa; y[d] = ya; op[d] = opa; in_valid[d] = 1'b1;
        model_eval(d, xa, ya, opa, e.z, e.dis);
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid[d] = 1'b0; x[d] = ~xa; y[d] = ~ya; op[d] = ~opa;
        check("in_ready_low_after_accept", d, 32'(in_ready[d]), 32'd0);
    endtask

    task automatic wait_out(input int d);
        int lat;
        lat = 0;
        while (out_valid[d] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid_latency", d, 32'(lat), 32'(reps(d)));
    endtask

    task automatic collect(input int d, input bit clr, input int hold, output logic [W-1:0] zact);
        exp_t e;
        zact = z[d];
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_underflow dut%0d", d);
            return;
        end
        e = sb.pop_front();
        check("z", d, 32'(z[d]), 32'(e.z));
        check("disagree", d, 32'(dis[d]), 32'(e.dis));
        repeat (hold) begin
            @(posedge clk); #1;
            check("z_stable_backpressure", d, 32'(z[d]), 32'(e.z));
        end
        out_ready[d] = 1'b1;
        err_clr[d]   = clr;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        err_clr[d]   = 1'b0;
        if (clr) exp_err[d] = 16'h0000;
        else if (e.dis && exp_err[d] != 16'hFFFF) exp_err[d] = exp_err[d] + 16'd1;
        check("err_count", d, 32'(err[d]), 32'(exp_err[d]));
        check("in_ready_after_handshake", d, 32'(in_ready[d]), 32'd1);
        check("out_valid_after_handshake", d, 32'(out_valid[d]), 32'd0);
        check("z_hold_after_handshake", d, 32'(z[d]), 32'(e.z));
    endtask

    initial begin
        logic [W-1:0] zact;
        logic [W-1:0] golden_z;
        logic [W-1:0] xr, yr;
        logic [1:0]   opr;
        exp_t         gold;

        vecs[0] = '{10'h3FF, 10'h3FF, 2'b00, 10'h000};
        vecs[1] = '{10'h0F0, 10'h0FF, 2'b00, 10'h30F};
        vecs[2] = '{10'h2AA, 10'h155, 2'b01, 10'h000};
        vecs[3] = '{10'h2AA, 10'h155, 2'b10, 10'h000};
        vecs[4] = '{10'h2AA, 10'h155, 2'b11, 10'h3FF};
        vecs[5] = '{10'h2AA, 10'h155, 2'b00, 10'h3FF};
        vecs[6] = '{10'h0F0, 10'h0FF, 2'b01, 10'h300};
        vecs[7] = '{10'h0F0, 10'h0FF, 2'b11, 10'h00F};

        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b1; in_valid[d] = 1'b0; x[d] = '0; y[d] = '0; op[d] = '0;
            out_ready[d] = 1'b0; err_clr[d] = 1'b0; exp_err[d] = 16'h0000;
            model_seed(d);
        end
        #12;
        for (int d = 0; d < ND; d++) begin
            check("rst_in_ready", d, 32'(in_ready[d]), 32'd1);
            check("rst_out_valid", d, 32'(out_valid[d]), 32'd0);
            check("rst_z", d, 32'(z[d]), 32'd0);
            check("rst_disagree", d, 32'(dis[d]), 32'd0);
            check("rst_err_count", d, 32'(err[d]), 32'd0);
        end
        @(negedge clk);
        for (int d = 0; d < ND; d++) rst[d] = 1'b0;

        // Clean gate functions against fixed expected results.
        for (int i = 0; i < 8; i++) begin
            start(0, vecs[i].x, vecs[i].y, vecs[i].op);
            wait_out(0);
            collect(0, 1'b0, 0, zact);
            check("vector_z", 0, 32'(zact), 32'(vecs[i].z));
        end

        // Long backpressure with ignored input pulses.
        start(0, 10'h0F0, 10'h0FF, 2'b00);
        wait_out(0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check("bp_z", 0, 32'(z[0]), 32'h30F);
            check("bp_in_ready", 0, 32'(in_ready[0]), 32'd0);
            check("bp_out_valid", 0, 32'(out_valid[0]), 32'd1);
            in_valid[0] = (k % 2 == 0);
            x[0] = 10'($urandom);
        end
        in_valid[0] = 1'b0;
        collect(0, 1'b0, 0, zact);
        repeat (2) begin
            @(posedge clk); #1;
            check("no_ghost_accept", 0, 32'(in_ready[0]), 32'd1);
        end

        // Reset during EVAL aborts and reseeds; the rerun must reproduce the first golden.
        start(1, 10'h1C7, 10'h2B4, 2'b11);
        gold = sb.pop_back();
        golden_z = gold.z;
        @(posedge clk); #1;
        rst[1] = 1'b1;
        #1;
        check("abort_out_valid", 1, 32'(out_valid[1]), 32'd0);
        check("abort_in_ready", 1, 32'(in_ready[1]), 32'd1);
        @(negedge clk);
        rst[1] = 1'b0;
        model_seed(1);
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_result", 1, 32'(out_valid[1]), 32'd0);
        start(1, 10'h1C7, 10'h2B4, 2'b11);
        wait_out(1);
        collect(1, 1'b0, 0, zact);
        check("rerun_matches_golden", 1, 32'(zact), 32'(golden_z));

        // Noisy voting against the reference model.
        for (int t = 0; t < 200; t++) begin
            xr = 10'($urandom); yr = 10'($urandom); opr = 2'($urandom);
            start(1, xr, yr, opr);
            wait_out(1);
            collect(1, 1'b0, $urandom_range(0, 2), zact);
        end

        // Saturation: preload just below full scale, then run disagreeing results.
        @(negedge clk);
        force dut_c.err_q = 16'hFFFE;
        #1;
        release dut_c.err_q;
        exp_err[2] = 16'hFFFE;
        check("preload", 2, 32'(err[2]), 32'hFFFE);
        for (int t = 0; t < 4; t++) begin
            start(2, 10'($urandom), 10'($urandom), 2'($urandom));
            wait_out(2);
            collect(2, 1'b0, 0, zact);
        end
        check("saturated", 2, 32'(err[2]), 32'hFFFF);
        start(2, 10'h155, 10'h0AA, 2'b10);
        wait_out(2);
        collect(2, 1'b1, 0, zact);
        check("clear_over_increment", 2, 32'(err[2]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
